regfile_dump: RTL and testbench
===============================

# regfile_dump

Debug read-out engine for the CPU register file. On a start pulse it walks register indices 0..NUM_REGS-1 through one spare regfile read port. It skips indices not selected by a mask and streams each selected value out over a valid/ready interface. It ends the stream with a checksum word. It sits beside `regfile` and replaces ad-hoc simulation prints with a synthesizable dump path for the test harness or a debug UART.

## Interface
- NUM_REGS, 32, number of registers walked
- ADDR_W, 5, register index width; NUM_REGS ≤ 2^ADDR_W
- DATA_W, 32, register data width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset (sampled on clk rising edge)
- start  in  1  request a dump; honoured only in IDLE
- sel_mask  in  NUM_REGS  bit i = 1 includes register i; sampled with start
- rd_addr  out  ADDR_W  index driven to regfile read port (combinational read)
- rd_data  in  DATA_W  value of regs[rd_addr], same cycle
- out_valid  out  1  out_data/out_index/out_last/out_is_sum valid
- out_ready  in  1  sink accepts word when high with out_valid
- out_data  out  DATA_W  register value or checksum
- out_index  out  ADDR_W  register index of word; 0 for checksum
- out_last  out  1  high only on checksum word
- out_is_sum  out  1  high only on checksum word
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after checksum accepted

## Operation
- FSM states: IDLE, READ, SEND, SUM, DONE.
- IDLE: when start=1, latch sel_mask, clear idx and sum, go to READ. start in any other state is ignored.
- READ: rd_addr = idx.
  - If mask[idx]=1, register rd_data into out_data, idx into out_index, add rd_data to sum, go to SEND.
  - If mask[idx]=0, skip. If idx = NUM_REGS-1, go to SUM; else idx+1 and stay in READ.
- SEND: out_valid=1. On out_valid & out_ready: if idx = NUM_REGS-1 go to SUM, else idx+1 and go to READ.
- SUM: out_valid=1, out_data=sum, out_index=0, out_last=1, out_is_sum=1. On handshake, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Checksum: sum of emitted register values mod 2^DATA_W; carry discarded. Skipped registers do not contribute.
- No atomic snapshot: each value is the register content in its own READ cycle. Writes to a register before its READ cycle are visible; writes after it are not.
- rd_addr holds the last idx outside READ. The regfile read is side-effect free, so this is harmless.

## Timing
- Reset (rst_n=0 at edge): state IDLE. Reset values:
  - out_valid, out_last, out_is_sum, busy, done = 0
  - out_data = 0, out_index = 0, rd_addr = 0
  - idx = 0, sum = 0, latched mask = 0
- Reset mid-dump aborts immediately. The partial stream is not terminated; the sink must discard it. No done pulse is issued.
- Start sampled at edge E0: READ during cycle E0..E1. A selected register's word is valid from edge E1 onward.
- Handshake rules:
  - out_data, out_index, out_last and out_is_sum are held stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a handshake, except on reset.
- Throughput, out_ready held 1: 2 cycles per selected register, 1 cycle per skipped register.
- All mask bits set, out_ready=1: checksum handshake at E0+65; done high during cycle E0+65..E0+66; IDLE at E0+66.
- out_ready may be high while out_valid=0; it has no effect.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with start=1 → all outputs 0, busy=0, no stream.
- Full dump: preload x3=99, x4=5, others 0; sel_mask=all ones; out_ready=1 → 32 words in index order 0..31 with values 0,0,0,99,5,0..., then sum word 104 with out_last=1; done pulses at E0+65.
- Backpressure: full dump, out_ready=0 for 3 cycles while index 4 is offered → out_data=5 and out_index=4 stable throughout; index 5 follows 2 cycles after ready returns; sum still 104.
- Sparse mask: sel_mask=0x18 → exactly two words (3:99, 4:5), then sum 104. done at E0+2+2+... matching 30 skip cycles plus 2×2 send cycles plus SUM handshake.
- Empty mask: sel_mask=0 → after 32 READ cycles, a single word out_data=0, out_is_sum=1, out_last=1, then done.
- Abort/restart: start pulse during busy → ignored, stream unchanged. rst_n=0 while word 10 is offered → out_valid=0 next cycle. A new start then restarts at index 0 with sum cleared (final sum 104).

Source files
------------

// File: rtl/regfile_dump.sv
// Debug dump engine: walks the register file through a spare read port and streams
// each masked register over valid/ready, then ends the stream with a checksum word.
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [NUM_REGS-1:0] sel_mask,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   rd_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [ADDR_W-1:0]   out_index,
    output logic                out_last,
    output logic                out_is_sum,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {IDLE, READ, SEND, SUM, DONE} state_t;

    // One captured register word, held while the sink back-pressures.
    typedef struct packed {
        logic [ADDR_W-1:0] index;
        logic [DATA_W-1:0] data;
    } beat_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t              state, state_nxt;
    logic [NUM_REGS-1:0] mask_r;
    logic [ADDR_W-1:0]   idx;
    logic [DATA_W-1:0]   sum;
    beat_t               beat;
    logic                sel;
    logic                at_last;
    logic                hs;

    assign sel     = mask_r[idx];
    assign at_last = (idx == LAST_IDX);
    assign hs      = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = READ;
            READ: begin
                if (sel)          state_nxt = SEND;
                else if (at_last) state_nxt = SUM;
            end
            SEND: if (hs) state_nxt = at_last ? SUM : READ;
            SUM:  if (hs) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: idx advances on a skip in READ or after a handshake in SEND.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_r <= '0;
            idx    <= '0;
            sum    <= '0;
            beat   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mask_r <= sel_mask;
                    idx    <= '0;
                    sum    <= '0;
                end
                READ: begin
                    if (sel) begin
                        beat.data  <= rd_data;
                        beat.index <= idx;
                        sum        <= sum + rd_data;
                    end else if (!at_last) begin
                        idx <= idx + 1'b1;
                    end
                end
                SEND: if (hs && !at_last) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_addr    = idx;
        busy       = (state != IDLE);
        out_valid  = 1'b0;
        out_data   = beat.data;
        out_index  = beat.index;
        out_last   = 1'b0;
        out_is_sum = 1'b0;
        done       = 1'b0;
        case (state)
            SEND: out_valid = 1'b1;
            SUM: begin
                out_valid  = 1'b1;
                out_data   = sum;
                out_index  = '0;
                out_last   = 1'b1;
                out_is_sum = 1'b1;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: directed and random dumps checked against a queue model
// of the expected word stream built from the mask and register contents.
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] sel_mask;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        out_last;
    logic        out_is_sum;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;
    assign rd_data = regs[rd_addr];

    regfile_dump #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sel_mask(sel_mask),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
        .out_last(out_last), .out_is_sum(out_is_sum), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] cur_word();
        return {25'd0, out_is_sum, out_last, out_index, out_data};
    endfunction

    // mode 0: ready always high, 1: random ready, 2: 3-cycle stall on index 4.
    task automatic run_dump(input string tag, input logic [31:0] mask, input int mode,
                            input int abort_idx, input bit poke, input int exp_done_k);
        logic [63:0] q[$];
        logic [63:0] held_w = '0;
        logic [31:0] s = '0;
        bit held = 0, fin = 0, r;
        int k = 0, stall = 0, hs4 = -100;
        for (int i = 0; i < 32; i++)
            if (mask[i]) begin
                q.push_back({25'd0, 1'b0, 1'b0, 5'(i), regs[i]});
                s += regs[i];
            end
        q.push_back({25'd0, 1'b1, 1'b1, 5'd0, s});

        @(negedge clk);
        start = 1'b1; sel_mask = mask;
        @(posedge clk);
        #1 start = 1'b0; sel_mask = $urandom;
        while (!fin && k < 3000) begin
            @(negedge clk);
            start = poke && (k == 5);
            if (start) sel_mask = ~mask;
            if (done) begin
                if (exp_done_k >= 0) check({tag, "_done_cycle"}, 64'(k), 64'(exp_done_k));
                check({tag, "_all_words"}, 64'(q.size()), 64'd0);
                fin = 1;
                @(negedge clk);
                check({tag, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
            end else begin
                check({tag, "_busy"}, 64'(busy), 64'd1);
                if (held) begin
                    check({tag, "_valid_held"}, 64'(out_valid), 64'd1);
                    check({tag, "_stable"}, cur_word(), held_w);
                end
                if (out_valid && abort_idx >= 0 && !out_is_sum && int'(out_index) == abort_idx) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    check({tag, "_abort"}, {61'd0, out_valid, busy, done}, 64'd0);
                    rst_n = 1'b1;
                    fin = 1;
                end else begin
                    case (mode)
                        1:       r = 1'($urandom_range(0, 1));
                        2:       if (out_valid && !out_is_sum && out_index == 5'd4 && stall < 3) begin
                                     r = 0; stall++;
                                 end else r = 1;
                        default: r = 1;
                    endcase
                    out_ready = r;
                    if (out_valid) begin
                        if (mode == 2 && !held && !out_is_sum && out_index == 5'd5)
                            check({tag, "_gap_after_stall"}, 64'(k - hs4), 64'd2);
                        if (r) begin
                            if (q.size() > 0) check({tag, "_word"}, cur_word(), q.pop_front());
                            else check({tag, "_extra_word"}, cur_word(), 64'd0 - 1);
                            if (!out_is_sum && out_index == 5'd4) hs4 = k;
                            held = 0;
                        end else begin
                            held = 1;
                            held_w = cur_word();
                        end
                    end else begin
                        held = 0;
                    end
                    k++;
                end
            end
        end
        if (!fin) check({tag, "_timeout"}, 64'd0, 64'd1);
        out_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        regs[3] = 32'd99;
        regs[4] = 32'd5;
        rst_n = 1'b0; start = 1'b1; sel_mask = '1; out_ready = 1'b1;

        // Reset held with start high: everything stays quiet.
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs",
                  {15'd0, out_valid, out_last, out_is_sum, busy, done, out_data, out_index, rd_addr},
                  64'd0);
        end
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {59'd0, out_valid, out_last, out_is_sum, busy, done}, 64'd0);

        run_dump("full",     32'hFFFF_FFFF, 0, -1, 0, 65);
        run_dump("backpres", 32'hFFFF_FFFF, 2, -1, 0, 68);
        run_dump("sparse",   32'h0000_0018, 0, -1, 0, 35);
        run_dump("empty",    32'h0000_0000, 0, -1, 0, 33);
        run_dump("poke",     32'hFFFF_FFFF, 0, -1, 1, 65);
        run_dump("abort",    32'hFFFF_FFFF, 0, 10, 0, -1);
        run_dump("restart",  32'hFFFF_FFFF, 0, -1, 0, 65);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            run_dump("random", $urandom, 1, -1, 0, -1);
        end
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        run_dump("random_full", 32'hFFFF_FFFF, 0, -1, 0, 65);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
